// File: rtl/act_stream_ctrl.sv
// act_stream_ctrl
//   Activation pass over one tile of accumulator results. Each signed partial
//   sum is arithmetically right-shifted, optionally ReLU-clamped (stage 1),
//   then saturated to OUT_WIDTH (stage 2) and emitted with an end-of-tile mark.
//
// Ports
//   clk, rst_n           clock (rising edge), synchronous active-low reset
//   start                one-cycle pulse, latches cfg_* and starts a tile (IDLE only)
//   cfg_len              tile length in elements (0 -> immediate done)
//   cfg_shift            requantization arithmetic right-shift amount
//   cfg_relu_en          clamp negative values to zero before saturation
//   s_valid/s_ready/s_data        accumulator input stream
//   m_valid/m_ready/m_data/m_last activation output stream, m_last on final element
//   busy                 high while the tile is running or draining
//   done                 one-cycle pulse when the tile completes
module act_stream_ctrl #(
    parameter int IN_WIDTH    = 32,
    parameter int OUT_WIDTH   = 8,
    parameter int CNT_WIDTH   = 16,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [CNT_WIDTH-1:0]   cfg_len,
    input  logic [SHIFT_WIDTH-1:0] cfg_shift,
    input  logic                   cfg_relu_en,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [IN_WIDTH-1:0]    s_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [OUT_WIDTH-1:0]   m_data,
    output logic                   m_last,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    localparam logic [CNT_WIDTH-1:0]       CNT_ONE = CNT_WIDTH'(1);
    localparam logic signed [IN_WIDTH-1:0] SAT_MAX = IN_WIDTH'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [IN_WIDTH-1:0] SAT_MIN = IN_WIDTH'(-(2 ** (OUT_WIDTH - 1)));

    state_t                       state_q, state_d;
    logic [CNT_WIDTH-1:0]         len_q, len_d;
    logic [CNT_WIDTH-1:0]         in_cnt_q, in_cnt_d;
    logic [CNT_WIDTH-1:0]         out_cnt_q, out_cnt_d;
    logic [SHIFT_WIDTH-1:0]       shift_q, shift_d;
    logic                         relu_q, relu_d;

    logic                         s1_valid_q, s1_valid_d;
    logic signed [IN_WIDTH-1:0]   s1_data_q, s1_data_d;
    logic                         s1_last_q, s1_last_d;
    logic                         s2_valid_q, s2_valid_d;
    logic [OUT_WIDTH-1:0]         s2_data_q, s2_data_d;
    logic                         s2_last_q, s2_last_d;

    logic                         en;
    logic                         s_hs;
    logic                         m_hs;
    logic                         in_is_last;
    logic signed [IN_WIDTH-1:0]   data_s;
    logic signed [IN_WIDTH-1:0]   shifted;

    // The whole pipeline moves together; a full, stalled stage 2 freezes everything.
    assign en         = !s2_valid_q || m_ready;
    assign s_ready    = (state_q == ST_RUN) && en && (in_cnt_q < len_q);
    assign s_hs       = s_valid && s_ready;
    assign m_hs       = s2_valid_q && m_ready;
    assign in_is_last = ((in_cnt_q + CNT_ONE) == len_q);
    assign data_s     = s_data;
    assign shifted    = data_s >>> shift_q;

    assign m_valid = s2_valid_q;
    assign m_data  = s2_data_q;
    assign m_last  = s2_last_q;
    assign busy    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done    = (state_q == ST_DONE);

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        shift_d   = shift_q;
        relu_d    = relu_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;

        if (m_hs) begin
            out_cnt_d = out_cnt_q + CNT_ONE;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_len != '0) begin
                        len_d     = cfg_len;
                        shift_d   = cfg_shift;
                        relu_d    = cfg_relu_en;
                        in_cnt_d  = '0;
                        out_cnt_d = '0;
                        state_d   = ST_RUN;
                    end else begin
                        state_d   = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                if (s_hs) begin
                    in_cnt_d = in_cnt_q + CNT_ONE;
                    if (in_is_last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (m_hs && ((out_cnt_q + CNT_ONE) == len_q)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_last_d  = s1_last_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_last_d  = s2_last_q;

        if (en) begin
            s1_valid_d = s_hs;
            s1_last_d  = s_hs && in_is_last;
            if (s_hs) begin
                s1_data_d = (relu_q && shifted[IN_WIDTH-1]) ? '0 : shifted;
            end

            s2_valid_d = s1_valid_q;
            s2_last_d  = s1_last_q;
            if (s1_valid_q) begin
                if (s1_data_q > SAT_MAX) begin
                    s2_data_d = SAT_MAX[OUT_WIDTH-1:0];
                end else if (s1_data_q < SAT_MIN) begin
                    s2_data_d = SAT_MIN[OUT_WIDTH-1:0];
                end else begin
                    s2_data_d = s1_data_q[OUT_WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            shift_q    <= '0;
            relu_q     <= 1'b0;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_last_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            shift_q    <= shift_d;
            relu_q     <= relu_d;
            in_cnt_q   <= in_cnt_d;
            out_cnt_q  <= out_cnt_d;
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_last_q  <= s1_last_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_last_q  <= s2_last_d;
        end
    end

endmodule

// File: tb/tb_act_stream_ctrl.sv
// Bench for act_stream_ctrl: directed tiles; expected outputs are queued as
// stimulus is issued and a negedge monitor pops/compares on each handshake.
module tb_act_stream_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] cfg_len = '0;
    logic [4:0]  cfg_shift = '0;
    logic        cfg_relu_en = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [7:0]  m_data;
    logic        m_last;
    logic        busy;
    logic        done;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   ready_mode = 0;
    int   out_seen = 0;
    int   last_seen = 0;
    int   done_cnt = 0;
    int   first_acc = -1;
    int   first_mv = -1;
    int   prev;
    logic exp_done = 1'b0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic prev_last = 1'b0;

    act_stream_ctrl #(
        .IN_WIDTH   (32),
        .OUT_WIDTH  (8),
        .CNT_WIDTH  (16),
        .SHIFT_WIDTH(5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cfg_len    (cfg_len),
        .cfg_shift  (cfg_shift),
        .cfg_relu_en(cfg_relu_en),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // m_ready: constant 1, or the repeating 1,0,0,1 backpressure pattern.
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) begin
                m_ready = 1'b1;
            end else begin
                m_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
                ph++;
            end
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
            exp_done   = 1'b0;
        end else begin
            if (exp_done) begin
                chk("done_after_last", done, 1);
                exp_done = 1'b0;
            end
            if (done) done_cnt++;
            if (prev_stall) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data", m_data, prev_data);
                chk("stall_last", m_last, prev_last);
            end
            if (m_valid && !m_ready) chk("s_ready_blocked", s_ready, 0);
            if (s_valid && s_ready && first_acc < 0) first_acc = cyc;
            if (m_valid && first_mv < 0) first_mv = cyc;
            if (m_valid && m_ready) begin
                out_seen++;
                if (m_last) last_seen++;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got data=%0d last=%0d, required no output", m_data, m_last);
                end else begin
                    mon_e = sb.pop_front();
                    chk("m_data", m_data, mon_e.data);
                    chk("m_last", m_last, mon_e.last);
                    if (mon_e.last) exp_done = 1'b1;
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    // All tasks start and end at posedge + 1.
    task automatic start_tile(input int len, input int sh, input logic relu);
        cfg_len     = 16'(len);
        cfg_shift   = 5'(sh);
        cfg_relu_en = relu;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send(input int d, input logic [7:0] e, input logic last);
        int   n;
        exp_t item;
        item.data = e;
        item.last = last;
        sb.push_back(item);
        n       = 0;
        s_valid = 1'b1;
        s_data  = d;
        @(negedge clk);
        while (!s_ready && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (!s_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: s_ready stayed 0, required 1");
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_data  = 32'hDEAD_BEEF;
    endtask

    task automatic wait_done(input int p);
        int n;
        n = 0;
        while (done_cnt == p && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("done_pulses", done_cnt - p, 1);
        chk("idle_busy", busy, 0);
        chk("sb_empty", sb.size(), 0);
    endtask

    task automatic clear_stats();
        out_seen  = 0;
        last_seen = 0;
        first_acc = -1;
        first_mv  = -1;
    endtask

    initial begin
        #300000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic tile with ReLU
        clear_stats();
        prev = done_cnt;
        start_tile(4, 0, 1'b1);
        chk("busy_run", busy, 1);
        send(5, 8'd5, 1'b0);
        send(-3, 8'd0, 1'b0);
        send(127, 8'd127, 1'b0);
        send(0, 8'd0, 1'b1);
        wait_done(prev);
        chk("t1_latency", first_mv - first_acc, 2);
        chk("t1_outputs", out_seen, 4);
        chk("t1_lasts", last_seen, 1);

        // Shift and saturate
        clear_stats();
        prev = done_cnt;
        start_tile(3, 4, 1'b0);
        send(32'h0000_1000, 8'd127, 1'b0);
        send(32'hFFFF_0000, 8'h80, 1'b0);
        send(-40, 8'hFD, 1'b1);
        wait_done(prev);
        chk("t2_outputs", out_seen, 3);

        // Backpressure
        clear_stats();
        prev = done_cnt;
        ready_mode = 1;
        start_tile(8, 1, 1'b0);
        send(10, 8'h05, 1'b0);
        send(-20, 8'hF6, 1'b0);
        send(300, 8'h7F, 1'b0);
        send(-300, 8'h80, 1'b0);
        send(7, 8'h03, 1'b0);
        send(-7, 8'hFC, 1'b0);
        send(255, 8'h7F, 1'b0);
        send(-256, 8'h80, 1'b1);
        wait_done(prev);
        ready_mode = 0;
        chk("t3_outputs", out_seen, 8);
        chk("t3_lasts", last_seen, 1);

        // Zero-length tile
        clear_stats();
        prev = done_cnt;
        start_tile(0, 0, 1'b0);
        @(negedge clk);
        chk("zl_done", done, 1);
        chk("zl_busy", busy, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("zl_done_low", done, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("zl_outputs", out_seen, 0);
        chk("zl_pulses", done_cnt - prev, 1);

        // Start ignored mid-tile
        clear_stats();
        prev = done_cnt;
        start_tile(2, 0, 1'b0);
        send(1, 8'd1, 1'b0);
        start_tile(5, 3, 1'b1);
        chk("ign_busy", busy, 1);
        send(-2, 8'hFE, 1'b1);
        wait_done(prev);
        repeat (4) @(posedge clk);
        #1;
        chk("ign_outputs", out_seen, 2);

        // Reset mid-tile
        clear_stats();
        start_tile(10, 0, 1'b0);
        send(11, 8'd11, 1'b0);
        send(12, 8'd12, 1'b0);
        send(13, 8'd13, 1'b0);
        send(14, 8'd14, 1'b0);
        send(15, 8'd15, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        @(negedge clk);
        chk("mrst_m_valid", m_valid, 0);
        chk("mrst_s_ready", s_ready, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_m_last", m_last, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        clear_stats();
        prev = done_cnt;
        start_tile(2, 0, 1'b0);
        send(100, 8'd100, 1'b0);
        send(-100, 8'h9C, 1'b1);
        wait_done(prev);
        chk("post_rst_outputs", out_seen, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
